// File: rtl/filtered_uart_tx.sv
// Buffers signed filtered samples in a small FIFO and serialises each one as a UART frame on tx.
// Define UART_PARITY_EN for 8E1 frames; the default build produces 8N1 frames.
module filtered_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic signed [7:0] sample,
  output logic              tx,
  output logic              busy,
  output logic              fifo_full,
  output logic              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state, state_next;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic            baud_end, pop, push;
`ifdef UART_PARITY_EN
  logic            par_bit;
`endif

  assign baud_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  // A frame is loaded from idle, or straight out of STOP so back-to-back frames have no gap.
  assign pop  = (count != '0) && ((state == S_IDLE) || ((state == S_STOP) && baud_end));
  assign push = sample_valid && ((count != CW'(FIFO_DEPTH)) || pop);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (pop) state_next = S_START;
      S_START: if (baud_end) state_next = S_DATA;
      S_DATA: begin
        if (baud_end && (bit_cnt == 3'd7)) begin
`ifdef UART_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (baud_end) state_next = S_STOP;
`endif
      S_STOP:  if (baud_end) state_next = pop ? S_START : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shreg[0];
`ifdef UART_PARITY_EN
      S_PARITY: tx = par_bit;
`endif
      default:  tx = 1'b1;
    endcase
  end

  // Baud counter restarts on every state or bit change; bits leave LSB first from shreg.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      if (pop) begin
        shreg   <= mem[rd_ptr];
        bit_cnt <= '0;
`ifdef UART_PARITY_EN
        par_bit <= ^mem[rd_ptr];
`endif
      end else if ((state == S_DATA) && baud_end) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if ((state == S_IDLE) || baud_end) baud_cnt <= '0;
      else                               baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count, so stale entries are never read.
  always_ff @(posedge CLK100MHZ) begin
    if (push) mem[wr_ptr] <= sample;
  end

  // busy and fifo_full are registered images of the next state/count, so they track them without lag.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      fifo_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      if (sample_valid && !push) overflow <= 1'b1;
      busy      <= (state_next != S_IDLE) || (count_next != '0);
      fifo_full <= (count_next == CW'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_filtered_uart_tx.sv
// Directed bench for filtered_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Frame vectors are hand-written in transmit order; the burst uses a small frame model.
module tb_filtered_uart_tx;

  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int NB  = 11;
`else
  localparam int NB  = 10;
`endif
  localparam int FL  = NB * CPB;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sample_valid;
  logic signed [7:0] sample;
  logic              tx, busy, fifo_full, overflow;

  int n_checks = 0;
  int n_errors = 0;

  filtered_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .CLK100MHZ   (clk),
    .reset       (rst_n),
    .sample_valid(sample_valid),
    .sample      (sample),
    .tx          (tx),
    .busy        (busy),
    .fifo_full   (fifo_full),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] time_bits;  // data bits in transmit order, leftmost first
    logic       parity;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int idx, input vec_t v);
    logic exp_bit;
    sample_valid = 1'b1;
    sample       = v.data;
    tick();
    sample_valid = 1'b0;
    check($sformatf("v%0d_busy_rise", idx), busy, 1);
    check($sformatf("v%0d_tx_idle", idx), tx, 1);
    for (int b = 0; b < NB; b++) begin
      if (b == 0)      exp_bit = 1'b0;
      else if (b <= 8) exp_bit = v.time_bits[8-b];
      else if (b == 9 && NB == 11) exp_bit = v.parity;
      else             exp_bit = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        tick();
        check($sformatf("v%0d_bit%0d_c%0d", idx, b, c), tx, exp_bit);
      end
      check($sformatf("v%0d_busy_bit%0d", idx, b), busy, 1);
    end
    tick();
    check($sformatf("v%0d_busy_fall", idx), busy, 0);
    check($sformatf("v%0d_tx_after", idx), tx, 1);
  endtask

  function automatic logic burst_tx(input int t);
    int u, f, bp;
    logic [7:0] v;
    if (t < 1 || t >= 1 + 5 * FL) return 1'b1;
    u  = t - 1;
    f  = u / FL;
    bp = (u % FL) / CPB;
    v  = 8'(f + 1);
    if (bp == 0) return 1'b0;
    if (bp <= 8) return v[bp-1];
    if (bp == 9 && NB == 11) return ^v;
    return 1'b1;
  endfunction

  initial begin
    vecs[0] = '{data: 8'hA5, time_bits: 8'b10100101, parity: 1'b0};
    vecs[1] = '{data: 8'h80, time_bits: 8'b00000001, parity: 1'b1};
    vecs[2] = '{data: 8'h07, time_bits: 8'b11100000, parity: 1'b1};
    vecs[3] = '{data: 8'h12, time_bits: 8'b01001000, parity: 1'b0};
    vecs[4] = '{data: 8'hFE, time_bits: 8'b01111111, parity: 1'b1};
    vecs[5] = '{data: 8'h3C, time_bits: 8'b00111100, parity: 1'b0};

    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample       = '0;

    // Reset held with random pushes: outputs must stay at reset values.
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'($urandom_range(0, 1));
      sample       = 8'($urandom);
      #2;
      check($sformatf("rst_tx_%0d", i), tx, 1);
      check($sformatf("rst_busy_%0d", i), busy, 0);
      check($sformatf("rst_full_%0d", i), fifo_full, 0);
      check($sformatf("rst_ovf_%0d", i), overflow, 0);
      tick();
    end
    sample_valid = 1'b0;
    rst_n        = 1'b1;
    tick();
    tick();
    check("post_rst_busy", busy, 0);

    for (int i = 0; i < 6; i++) begin
      send_frame(i, vecs[i]);
      tick();
    end

    // Burst of six pushes into a depth-4 FIFO; t counts cycles after the first push edge.
    sample_valid = 1'b1;
    sample       = 8'sd1;
    for (int t = 0; t <= 5 * FL + 3; t++) begin
      tick();
      check($sformatf("burst_tx_t%0d", t), tx, burst_tx(t));
      check($sformatf("burst_busy_t%0d", t), busy, (t <= 5 * FL) ? 1 : 0);
      if (t <= 5) begin
        check($sformatf("burst_full_t%0d", t), fifo_full, (t >= 4) ? 1 : 0);
        check($sformatf("burst_ovf_t%0d", t), overflow, (t == 5) ? 1 : 0);
      end else begin
        check($sformatf("burst_ovf_sticky_t%0d", t), overflow, 1);
      end
      if (t < 5) begin
        sample_valid = 1'b1;
        sample       = 8'(t + 2);
      end else begin
        sample_valid = 1'b0;
      end
    end

    // Reset during DATA bit 3 of 0xA5 with a second sample queued.
    sample_valid = 1'b1;
    sample       = 8'hA5;
    tick();
    sample       = 8'h3C;
    tick();
    sample_valid = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    check("mid_tx_bit3", tx, 0);
    check("mid_busy", busy, 1);
    check("mid_ovf_before", overflow, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_full", fifo_full, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      check($sformatf("after_rst_tx_%0d", i), tx, 1);
      check($sformatf("after_rst_busy_%0d", i), busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
